// File: rtl/rcu_pll_seq.sv
// PLL bring-up and core-clock switch sequencer for the reset and clock unit.
// Optional loss-of-lock monitor in IDLE: define RCU_PLL_SEQ_LOL_MON_EN.
module rcu_pll_seq #(
    parameter int                   CFG_WIDTH   = 3,
    parameter logic [CFG_WIDTH-1:0] CFG_RST     = '0,
    parameter int                   SETTLE_CYC  = 4,
    parameter int                   LOCK_STABLE = 16,
    parameter int                   TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_valid_i,
    input  logic [CFG_WIDTH-1:0] req_cfg_i,
    output logic                 req_ready_o,
    input  logic                 pll_lock_i,
    output logic [CFG_WIDTH-1:0] pll_cfg_o,
    output logic                 pll_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 lol_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
    // Abort lands TIMEOUT_CYC cycles after the CFG cycle, one edge ahead of the last LOCK count.
    localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYC - 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BYPASS = 3'd1;
    localparam logic [2:0] ST_CFG    = 3'd2;
    localparam logic [2:0] ST_LOCK   = 3'd3;
    localparam logic [2:0] ST_SWITCH = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]           state_q;
    logic [CFG_WIDTH-1:0] cfg_q;
    logic [SW-1:0]        settle_cnt;
    logic [CW-1:0]        stable_cnt;
    logic [CW-1:0]        tmo_cnt;
`ifdef RCU_PLL_SEQ_LOL_MON_EN
    logic                 lol_low_q;
`endif

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);

`ifndef RCU_PLL_SEQ_LOL_MON_EN
    assign lol_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cfg_q      <= CFG_RST;
            pll_cfg_o  <= CFG_RST;
            pll_en_o   <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            settle_cnt <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
`ifdef RCU_PLL_SEQ_LOL_MON_EN
            lol_o      <= 1'b0;
            lol_low_q  <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        // Fall back to the oscillator before anything touches the PLL.
                        cfg_q      <= req_cfg_i;
                        err_o      <= 1'b0;
                        pll_en_o   <= 1'b0;
                        settle_cnt <= '0;
                        state_q    <= ST_BYPASS;
`ifdef RCU_PLL_SEQ_LOL_MON_EN
                        lol_o      <= 1'b0;
                        lol_low_q  <= 1'b0;
                    end else if (pll_en_o) begin
                        if (pll_lock_i) begin
                            lol_low_q <= 1'b0;
                        end else if (lol_low_q) begin
                            pll_en_o  <= 1'b0;
                            lol_o     <= 1'b1;
                            lol_low_q <= 1'b0;
                        end else begin
                            lol_low_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_BYPASS: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        pll_cfg_o <= cfg_q;
                        state_q   <= ST_CFG;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_CFG: begin
                    stable_cnt <= '0;
                    tmo_cnt    <= '0;
                    state_q    <= ST_LOCK;
                end
                ST_LOCK: begin
                    if (pll_lock_i && (stable_cnt == STABLE_LAST)) begin
                        pll_en_o   <= 1'b1;
                        settle_cnt <= '0;
                        state_q    <= ST_SWITCH;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_o    <= 1'b1;
                        pll_en_o <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        tmo_cnt    <= tmo_cnt + 1'b1;
                        stable_cnt <= pll_lock_i ? stable_cnt + 1'b1 : '0;
                    end
                end
                ST_SWITCH: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        done_o  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
